// File: rtl/jk_mode_counter_pkg.sv
// Shared types and parameter-legality helper for the JK mode counter.
// Optional build macro consumers: JK_MODE_COUNTER_SAT_EN (see jk_mode_counter).
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        JK   = 2'b11
    } jk_mode_t;

    // Encodings are {j, k} so a cell can cast its inputs directly.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'b00,
        ACT_CLEAR  = 2'b01,
        ACT_SET    = 2'b10,
        ACT_TOGGLE = 2'b11
    } jk_action_t;

    function automatic bit params_ok(input int width, input int modulus, input int reset_val);
        return (width >= 2) && (width <= 16) &&
               (modulus >= 2) && (modulus <= (1 << width)) &&
               (reset_val >= 0) && (reset_val < modulus);
    endfunction

endpackage

// File: rtl/jk_mode_counter_if.sv
// Control/status bundle for jk_mode_counter; master drives controls, slave is the counter.
interface jk_mode_counter_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             en;
    jk_mode_t         mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             wrap;

    modport master (output en, mode, j, k, load, din, input q, q_bar, tc, wrap);
    modport slave  (input en, mode, j, k, load, din, output q, q_bar, tc, wrap);
endinterface

// File: rtl/jk_mode_counter_cell.sv
// Single JK storage stage with async active-high reset to a per-bit value
// and a synchronous load path that takes priority over the J/K action.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    input  logic load,
    input  logic load_val,
    input  logic en,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= rst_val;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            case (jk_action_t'({j, k}))
                ACT_CLEAR:  q <= 1'b0;
                ACT_SET:    q <= 1'b1;
                ACT_TOGGLE: q <= ~q;
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mode_counter.sv
// WIDTH-stage JK register/counter: hold, modulo up/down count, or per-bit JK.
// Define JK_MODE_COUNTER_SAT_EN to saturate at the count limits instead of wrapping.
module jk_mode_counter
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    jk_mode_counter_if.slave  bus
);

    if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_bad_params
        $error("jk_mode_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    // WIDTH+1 bit limits keep MODULUS = 2^WIDTH representable.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_W   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
`ifdef JK_MODE_COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] UP_END   = MAX_Q;
    localparam logic [WIDTH-1:0] DOWN_END = '0;
`else
    localparam logic [WIDTH-1:0] UP_END   = '0;
    localparam logic [WIDTH-1:0] DOWN_END = MAX_Q;
`endif

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] din_clamped;
    logic [WIDTH-1:0] load_val;
    logic             at_top;
    logic             at_zero;
    logic             count_step;
    logic             cell_load;
    logic             jk_en;
    logic             tc_int;

    assign at_top      = {1'b0, q} >= TOP_W;
    assign at_zero     = (q == '0);
    assign din_clamped = ({1'b0, bus.din} < MOD_W) ? bus.din : MAX_Q;

    always_comb begin
        cnt_nxt = q;
        case (bus.mode)
            UP:      cnt_nxt = at_top  ? UP_END   : q + 1'b1;
            DOWN:    cnt_nxt = at_zero ? DOWN_END : q - 1'b1;
            default: cnt_nxt = q;
        endcase
    end

    // Counting reuses each cell's load path; JK mode uses the J/K path.
    assign count_step = bus.en & ((bus.mode == UP) | (bus.mode == DOWN));
    assign cell_load  = bus.load | count_step;
    assign load_val   = bus.load ? din_clamped : cnt_nxt;
    assign jk_en      = bus.en & ~bus.load & (bus.mode == JK);

    assign tc_int = bus.en & ~bus.load &
                    (((bus.mode == UP) & at_top) | ((bus.mode == DOWN) & at_zero));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .rst_val  (RST_Q[i]),
            .j        (bus.j[i]),
            .k        (bus.k[i]),
            .load     (cell_load),
            .load_val (load_val[i]),
            .en       (jk_en),
            .q        (q[i])
        );
    end

`ifdef JK_MODE_COUNTER_SAT_EN
    assign bus.wrap = 1'b0;
`else
    logic wrap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc_int;
        end
    end

    assign bus.wrap = wrap_q;
`endif

    assign bus.q     = q;
    assign bus.q_bar = ~q;
    assign bus.tc    = tc_int;

endmodule

// File: tb/tb_jk_mode_counter.sv
// Scoreboard bench for jk_mode_counter (WIDTH=4, MODULUS=10, RESET_VAL=3).
// Expected values follow the build: JK_MODE_COUNTER_SAT_EN selects saturating expectations.
module tb_jk_mode_counter;
    import jk_pkg::*;

`ifdef JK_MODE_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    jk_mode_counter_if #(.WIDTH(4)) intf ();

    jk_mode_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: compares whatever is pending at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".q"},     intf.q,            e.q);
                check({e.name, ".q_bar"}, intf.q_bar,        ~e.q);
                check({e.name, ".tc"},    {3'b0, intf.tc},   {3'b0, e.tc});
                check({e.name, ".wrap"},  {3'b0, intf.wrap}, {3'b0, e.wrap});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string nm, input logic [3:0] eq, input logic etc, input logic ew);
        exp_t e;
        e.name = nm;
        e.q    = eq;
        e.tc   = etc;
        e.wrap = ew;
        sb.push_back(e);
    endtask

    // Inputs are held for one cycle; expectations describe that same cycle.
    task automatic step(input string nm, input logic e, input jk_mode_t m,
                        input logic [3:0] jj, input logic [3:0] kk,
                        input logic ld, input logic [3:0] d,
                        input logic [3:0] eq, input logic etc, input logic ew);
        intf.en   = e;
        intf.mode = m;
        intf.j    = jj;
        intf.k    = kk;
        intf.load = ld;
        intf.din  = d;
        push(nm, eq, etc, ew);
        @(posedge clk);
        #1;
    endtask

    initial begin
        intf.en   = 1'b0;
        intf.mode = HOLD;
        intf.j    = '0;
        intf.k    = '0;
        intf.load = 1'b0;
        intf.din  = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        push("reset", 4'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("after_rst", 0, HOLD, 4'h0, 4'h0, 0, 4'd0,  4'd3, 0, 0);
        step("load8",     1, UP,   4'h0, 4'h0, 1, 4'd8,  4'd3, 0, 0);
        step("up8",       1, UP,   4'h0, 4'h0, 0, 4'd0,  4'd8, 0, 0);
        step("up9_tc",    1, UP,   4'h0, 4'h0, 0, 4'd0,  4'd9, 1, 0);
        step("up_wrap",   1, UP,   4'h0, 4'h0, 0, 4'd0,  SAT ? 4'd9 : 4'd0, SAT, !SAT);
        step("up_next",   1, UP,   4'h0, 4'h0, 0, 4'd0,  SAT ? 4'd9 : 4'd1, SAT, 0);
        step("load0",     0, HOLD, 4'h0, 4'h0, 1, 4'd0,  SAT ? 4'd9 : 4'd2, 0, 0);
        step("down0_tc",  1, DOWN, 4'h0, 4'h0, 0, 4'd0,  4'd0, 1, 0);
        step("load12",    1, DOWN, 4'h0, 4'h0, 1, 4'd12, SAT ? 4'd0 : 4'd9, 0, !SAT);
        step("clamped",   1, DOWN, 4'h0, 4'h0, 0, 4'd0,  4'd9, 0, 0);
        step("load5",     1, HOLD, 4'h0, 4'h0, 1, 4'd5,  4'd8, 0, 0);
        step("jk_apply",  1, JK,   4'hC, 4'hA, 0, 4'd0,  4'd5, 0, 0);
        step("jk_result", 1, UP,   4'h0, 4'h0, 0, 4'd0,  4'd13, 1, 0);
        step("oor_wrap",  1, HOLD, 4'h0, 4'h0, 0, 4'd0,  SAT ? 4'd9 : 4'd0, 0, !SAT);
        step("load9",     0, UP,   4'h0, 4'h0, 1, 4'd9,  SAT ? 4'd9 : 4'd0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("en_low", 0, UP, 4'h0, 4'h0, 0, 4'd0, 4'd9, 0, 0);
        end
        step("down9",     1, DOWN, 4'h0, 4'h0, 0, 4'd0,  4'd9, 0, 0);
        step("jk_en_low", 0, JK,   4'hF, 4'hF, 0, 4'd0,  4'd8, 0, 0);
        step("jk_clear",  1, JK,   4'h0, 4'hF, 0, 4'd0,  4'd8, 0, 0);
        step("jk_set",    1, JK,   4'hF, 4'h0, 0, 4'd0,  4'd0, 0, 0);
        step("oor_down",  1, DOWN, 4'h0, 4'h0, 0, 4'd0,  4'd15, 0, 0);
        step("oor_dec",   1, HOLD, 4'h0, 4'h0, 0, 4'd0,  4'd14, 0, 0);
        step("load9b",    1, HOLD, 4'h0, 4'h0, 1, 4'd9,  4'd14, 0, 0);
        step("up9b",      1, UP,   4'h0, 4'h0, 0, 4'd0,  4'd9, 1, 0);

        // Reset lands mid-cycle while a wrap pulse is pending.
        #2;
        rst = 1'b1;
        push("rst_mid", 4'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("resume",    1, UP,   4'h0, 4'h0, 0, 4'd0,  4'd3, 0, 0);
        step("resumed",   1, HOLD, 4'h0, 4'h0, 0, 4'd0,  4'd4, 0, 0);

        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
